// File: rtl/tone_sequencer.sv
// Purpose: Simon tone sequencer; owns the one-hot led_color bus, plays stored patterns, echoes button presses.
// Latency: start -> first tone on the 3rd clock after start is sampled; button press -> tone on the next clock.
// Backpressure: none; a held button does not retrigger until released, and start is ignored outside IDLE.
module tone_sequencer #(
  parameter int TONE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int MAX_LEN     = 32,
  localparam int ADDR_W     = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [1:0]        seq_data,
  input  logic [3:0]        btn,
  output logic [3:0]        led_color,
  output logic              busy,
  output logic              done,
  output logic              press_valid,
  output logic [1:0]        press_idx
);

  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_TONE,
    S_GAP,
    S_DONE,
    S_ECHO,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W:0]  idx;
  logic [ADDR_W:0]  len;
  logic [ADDR_W:0]  idx_nxt;
  logic [ADDR_W:0]  len_clamp;

  // Red has the highest priority when several buttons are down at once.
  function automatic logic [1:0] low_idx(input logic [3:0] b);
    logic [1:0] r;
    r = 2'd3;
    if (b[2]) r = 2'd2;
    if (b[1]) r = 2'd1;
    if (b[0]) r = 2'd0;
    return r;
  endfunction

  assign idx_nxt   = idx + IDX_ONE;
  assign len_clamp = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;

  // Single sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      led_color   <= '0;
      seq_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      press_valid <= 1'b0;
      press_idx   <= '0;
      cnt         <= '0;
      idx         <= '0;
      len         <= '0;
    end else begin
      done        <= 1'b0;
      press_valid <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Cancel wins over every other transition and never produces a done pulse.
        state     <= S_IDLE;
        led_color <= '0;
        busy      <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              len  <= len_clamp;
              idx  <= '0;
              cnt  <= '0;
              busy <= 1'b1;
              if (len_clamp == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_FETCH;
                seq_addr <= '0;
              end
            end else if (!start && btn != 4'b0000) begin
              // Playback outranks echo: a same-cycle start suppresses the press.
              state       <= S_ECHO;
              press_valid <= 1'b1;
              press_idx   <= low_idx(btn);
              led_color   <= 4'b0001 << low_idx(btn);
              busy        <= 1'b1;
              cnt         <= '0;
            end
          end
          S_FETCH: begin
            // RAM samples seq_addr on this edge; data is ready for LOAD.
            state <= S_LOAD;
          end
          S_LOAD: begin
            state     <= S_TONE;
            led_color <= 4'b0001 << seq_data;
            cnt       <= '0;
          end
          S_TONE: begin
            if (cnt == TONE_LAST) begin
              state     <= S_GAP;
              led_color <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (idx_nxt == len) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                idx      <= idx_nxt;
                seq_addr <= idx_nxt[ADDR_W-1:0];
                state    <= S_FETCH;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ECHO: begin
            if (cnt == TONE_LAST) begin
              state     <= S_RELEASE;
              led_color <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_RELEASE: begin
            // Hold here until every button is up so a held button cannot retrigger.
            if (btn == 4'b0000) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            led_color <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
